// File: rtl/delay_pkg.sv
// delay_pkg: shared state encoding, tap limit and saturating add for the multitap delay engine
package delay_pkg;
  localparam int MAX_TAPS = 8;
  typedef enum logic [2:0] {CLEAR, IDLE, READ, MIX, WRITE, OUT} state_t;
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a, input logic signed [63:0] b, input int sample_w);
    logic signed [63:0] s, hi, lo;
    s  = a + b;
    hi = (64'sd1 <<< (sample_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return s > hi ? hi : s < lo ? lo : s;
  endfunction
endpackage

// File: rtl/delay_gain_mac.sv
// delay_gain_mac: y = sat(a + ((g * w) >>> GAIN_W)), g unsigned fraction, a/w signed
//   a: signed sample, g: unsigned gain, w: signed wet value, y: saturated signed result
module delay_gain_mac
  import delay_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int GAIN_W   = 8,
  parameter int WET_W    = 18
) (
  input  logic signed [SAMPLE_W-1:0] a,
  input  logic        [GAIN_W-1:0]   g,
  input  logic signed [WET_W-1:0]    w,
  output logic signed [SAMPLE_W-1:0] y
);
  logic signed [GAIN_W+WET_W:0] p;
  assign p = $signed({1'b0, g}) * w;
  assign y = SAMPLE_W'(sat_add(64'(a), 64'(p >>> GAIN_W), SAMPLE_W));
endmodule

// File: rtl/multitap_delay_engine.sv
// multitap_delay_engine: per sample, sums NUM_TAPS delayed reads from ring memory, writes in+feedback, outputs dry+wet
//   in_*: sample input handshake, out_*: sample output handshake, tap_delay/fb_gain/mix_gain/bypass: per-sample controls
//   mem_*: req/ack memory port; one transaction per req, ack is a one-cycle pulse with rdata
module multitap_delay_engine
  import delay_pkg::*;
#(
  parameter int SAMPLE_W     = 16,
  parameter int ADDR_W       = 17,
  parameter int NUM_TAPS     = 2,
  parameter int GAIN_W       = 8,
  parameter bit CLEAR_ON_RST = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic signed [SAMPLE_W-1:0]   in_sample,
  output logic                         in_ready,
  input  logic [NUM_TAPS*ADDR_W-1:0]   tap_delay,
  input  logic [GAIN_W-1:0]            fb_gain,
  input  logic [GAIN_W-1:0]            mix_gain,
  input  logic                         bypass,
  output logic                         out_valid,
  output logic signed [SAMPLE_W-1:0]   out_sample,
  input  logic                         out_ready,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic signed [SAMPLE_W-1:0]   mem_wdata,
  input  logic                         mem_ack,
  input  logic signed [SAMPLE_W-1:0]   mem_rdata
);
  localparam int LG    = $clog2(NUM_TAPS);
  localparam int ACC_W = SAMPLE_W + LG + 1;
  localparam int TI_W  = NUM_TAPS > 1 ? LG : 1;
  localparam state_t RST_ST = CLEAR_ON_RST ? CLEAR : IDLE;
  state_t state, nxt;
  logic [ADDR_W-1:0] wp;
  logic [ADDR_W-1:0] taps [NUM_TAPS];
  logic [NUM_TAPS-1:0] pend, en;
  logic [TI_W-1:0] sel;
  logic signed [ACC_W-1:0] acc, wet, wet_g;
  logic signed [SAMPLE_W-1:0] in_l, out_mix, wr_mix;
  logic [GAIN_W-1:0] fb_l, mix_l;
  logic byp_l, ack_v;
  assign ack_v = mem_ack && mem_req;
  assign wet   = acc >>> LG;
  assign wet_g = byp_l ? '0 : wet;
  always_comb begin
    en = '0;
    for (int k = 0; k < NUM_TAPS; k++) en[k] = |tap_delay[k*ADDR_W +: ADDR_W];
  end
  // lowest pending tap; stays put while its read is outstanding since pend only changes on ack
  always_comb begin
    sel = '0;
    for (int k = NUM_TAPS - 1; k >= 0; k--) if (pend[k]) sel = TI_W'(k);
  end
  always_ff @(posedge clk) state <= rst ? RST_ST : nxt;
  always_comb begin
    nxt = state;
    case (state)
      CLEAR:   nxt = (ack_v && &mem_addr) ? IDLE : CLEAR;
      IDLE:    nxt = in_valid ? READ : IDLE;
      READ:    nxt = (!mem_req && ~|pend) ? MIX : READ;
      MIX:     nxt = WRITE;
      WRITE:   nxt = ack_v ? OUT : WRITE;
      OUT:     nxt = out_ready ? IDLE : OUT;
      default: nxt = RST_ST;
    endcase
  end
  always_comb begin
    in_ready  = !rst && state == IDLE;
    out_valid = !rst && state == OUT;
  end
  // a new request is only raised while mem_req is low, which guarantees the idle cycle after each ack
  always_ff @(posedge clk) begin
    if (rst) begin
      wp         <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      out_sample <= '0;
      acc        <= '0;
      pend       <= '0;
    end else begin
      case (state)
        CLEAR:
          if (!mem_req) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_wdata <= '0;
          end else if (ack_v) begin
            mem_req  <= 1'b0;
            mem_addr <= mem_addr + 1'b1;
          end
        IDLE:
          if (in_valid) begin
            in_l  <= in_sample;
            fb_l  <= fb_gain;
            mix_l <= mix_gain;
            byp_l <= bypass;
            acc   <= '0;
            pend  <= en;
            for (int k = 0; k < NUM_TAPS; k++) taps[k] <= tap_delay[k*ADDR_W +: ADDR_W];
          end
        READ:
          if (!mem_req && |pend) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= wp - taps[sel];
          end else if (ack_v) begin
            mem_req   <= 1'b0;
            acc       <= acc + ACC_W'(mem_rdata);
            pend[sel] <= 1'b0;
          end
        MIX: begin
          out_sample <= out_mix;
          mem_wdata  <= wr_mix;
          mem_addr   <= wp;
        end
        WRITE:
          if (!mem_req) begin
            mem_req <= 1'b1;
            mem_we  <= 1'b1;
          end else if (ack_v) begin
            mem_req <= 1'b0;
            wp      <= wp + 1'b1;
          end
        default: ;
      endcase
    end
  end
  delay_gain_mac #(.SAMPLE_W(SAMPLE_W), .GAIN_W(GAIN_W), .WET_W(ACC_W)) u_out (
    .a(in_l), .g(mix_l), .w(wet_g), .y(out_mix)
  );
  delay_gain_mac #(.SAMPLE_W(SAMPLE_W), .GAIN_W(GAIN_W), .WET_W(ACC_W)) u_wr (
    .a(in_l), .g(fb_l), .w(wet_g), .y(wr_mix)
  );
endmodule

// File: tb/tb_multitap_delay_engine.sv
// tb_multitap_delay_engine: directed checks of the multitap delay engine against a random-latency RAM model
module tb_multitap_delay_engine;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_ready, bypass = 1'b0;
  logic out_valid, out_ready = 1'b0, mem_req, mem_we, mem_ack = 1'b0;
  logic signed [15:0] in_sample = '0, out_sample, mem_wdata, mem_rdata = '0;
  logic [7:0] tap_delay = '0, fb_gain = '0, mix_gain = '0;
  logic [3:0] mem_addr;
  logic signed [15:0] ram [16];
  logic [3:0] waddr_log [64];
  logic signed [15:0] wdata_log [64];
  logic [3:0] last_raddr = '0;
  int wcnt = 0, dly = 0;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  multitap_delay_engine #(.SAMPLE_W(16), .ADDR_W(4), .NUM_TAPS(2), .GAIN_W(8), .CLEAR_ON_RST(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sample(in_sample), .in_ready(in_ready),
    .tap_delay(tap_delay), .fb_gain(fb_gain), .mix_gain(mix_gain), .bypass(bypass),
    .out_valid(out_valid), .out_sample(out_sample), .out_ready(out_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );
  always @(posedge clk) begin
    mem_ack <= 1'b0;
    if (rst) begin
      dly  <= 0;
      wcnt <= 0;
    end else if (mem_req && !mem_ack) begin
      if (dly > 0) dly <= dly - 1;
      else begin
        mem_ack <= 1'b1;
        dly     <= $urandom_range(0, 3);
        if (mem_we) begin
          ram[mem_addr] <= mem_wdata;
          if (wcnt < 64) begin
            waddr_log[wcnt] <= mem_addr;
            wdata_log[wcnt] <= mem_wdata;
          end
          wcnt <= wcnt + 1;
        end else begin
          mem_rdata  <= ram[mem_addr];
          last_raddr <= mem_addr;
        end
      end
    end
  end
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic wait_ready(output int ov);
    int n = 0;
    ov = 0;
    while (!in_ready && n < 400) begin
      @(negedge clk);
      n++;
      if (out_valid) ov++;
    end
  endtask
  task automatic do_reset(input bit full);
    int ov, errs;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    if (full) begin
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_sample", out_sample, 0);
      check("rst_mem_req", mem_req, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
    end
    rst = 1'b0;
    wait_ready(ov);
    check("clr_ready", in_ready, 1);
    check("clr_writes", wcnt, 16);
    if (full) begin
      errs = 0;
      for (int i = 0; i < 16; i++) if (waddr_log[i] != 4'(i) || wdata_log[i] != 0) errs++;
      check("clr_log", errs, 0);
      check("clr_no_out", ov, 0);
    end
  endtask
  task automatic send(input int x, output int y);
    int n = 0;
    while (!in_ready && n < 400) begin @(negedge clk); n++; end
    if (!in_ready) check("in_tmo", in_ready, 1);
    in_sample = 16'(x);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 400) begin @(negedge clk); n++; end
    if (!out_valid) check("out_tmo", out_valid, 1);
    y = out_sample;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end
  initial begin
    int y, n, ov, errs;
    @(negedge clk);
    do_reset(1'b1);
    tap_delay = 8'h03; mix_gain = 8'd128; fb_gain = 8'd0;
    for (int i = 0; i < 10; i++) begin
      send(i == 0 ? 1000 : 0, y);
      check($sformatf("echo_s%0d", i), y, i == 0 ? 1000 : i == 3 ? 250 : 0);
    end
    do_reset(1'b0);
    fb_gain = 8'd128;
    for (int i = 0; i < 10; i++) begin
      send(i == 0 ? 1000 : 0, y);
      check($sformatf("fb_s%0d", i), y, i == 0 ? 1000 : i == 3 ? 250 : i == 6 ? 62 : i == 9 ? 15 : 0);
    end
    do_reset(1'b0);
    tap_delay = 8'h01; mix_gain = 8'd255; fb_gain = 8'd255;
    for (int i = 0; i < 4; i++) begin
      send(32000, y);
      check($sformatf("sat_pos_s%0d", i), y, i == 0 ? 32000 : 32767);
    end
    check("sat_pos_ram1", ram[1], 32767);
    check("sat_pos_ram3", ram[3], 32767);
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) begin
      send(-32000, y);
      check($sformatf("sat_neg_s%0d", i), y, i == 0 ? -32000 : -32768);
    end
    check("sat_neg_ram2", ram[2], -32768);
    do_reset(1'b0);
    tap_delay = 8'h05; mix_gain = 8'd128; fb_gain = 8'd0;
    for (int i = 0; i < 20; i++) begin
      send(i == 0 ? 1000 : i == 14 ? 800 : 0, y);
      check($sformatf("wrap_s%0d", i), y, i == 0 ? 1000 : i == 5 ? 250 : i == 14 ? 800 : i == 19 ? 200 : 0);
      if (i == 18) check("wrap_raddr", last_raddr, 13);
    end
    bypass = 1'b1; fb_gain = 8'd255; mix_gain = 8'd255;
    send(100, y);
    check("bypass_out", y, 100);
    check("bypass_ram4", ram[4], 100);
    bypass = 1'b0;
    do_reset(1'b0);
    tap_delay = 8'h03; mix_gain = 8'd128; fb_gain = 8'd0;
    in_sample = 16'sd1234;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 400) begin @(negedge clk); n++; end
    check("hold_valid", out_valid, 1);
    y = out_sample;
    errs = 0;
    repeat (50) begin
      @(negedge clk);
      if (!out_valid || out_sample != 16'(y) || in_ready) errs++;
    end
    check("hold_stable", errs, 0);
    check("hold_val", y, 1234);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("hold_release", out_valid, 0);
    in_sample = 16'sd5;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!(mem_req && !mem_we) && n < 50) begin @(negedge clk); n++; end
    check("read_seen", int'(mem_req && !mem_we), 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_req_low", mem_req, 0);
    check("rst_no_out", out_valid, 0);
    rst = 1'b0;
    n = 0;
    while (!mem_req && n < 50) begin @(negedge clk); n++; end
    check("clr_restart_addr", mem_addr, 0);
    check("clr_restart_we", mem_we, 1);
    wait_ready(ov);
    check("clr_restart_ready", in_ready, 1);
    check("clr_restart_writes", wcnt, 16);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
